sap1_datapath: RTL

SAP1_DATAPATH -- requirements
Module: sap1_datapath

---
 rtl/sap1_datapath.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, MDR, IR, A, B, OUT, 16x8 RAM, and the shared
// 8-bit bus with a fixed-priority driver mux and a sticky conflict flag.
// Optional feature macro: SAP1_FLAGS_EN (zero/carry flags from the ALU).
module sap1_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] ctrl,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [3:0]  opcode,
  output logic [7:0]  out_val,
  output logic [7:0]  bus_dbg,
  output logic        bus_conflict,
  output logic        zero_flag,
  output logic        carry_flag
);

  // Control word fields, MSB first so the cast lines up with the bit map.
  typedef struct packed {
    logic pc_inc;
    logic pc_en;
    logic pc_load;
    logic mar_addr_load_n;
    logic mar_mem_load_n;
    logic ram_en_n;
    logic ram_load_n;
    logic ir_load_n;
    logic ir_en_n;
    logic rega_load_n;
    logic rega_en;
    logic adder_sub;
    logic regb_en;
    logic regb_load_n;
    logic out_load_n;
  } ctrl_t;

  ctrl_t       cw;
  logic [3:0]  pc, mar;
  logic [7:0]  mdr, ir, a, b, outr;
  logic [7:0]  ram [0:15];
  logic [7:0]  alu;
  logic [7:0]  bus;
  logic [4:0]  drv;
  logic        multi_drv;

  assign cw = ctrl;

`ifdef SAP1_FLAGS_EN
  logic [8:0] alu_sum;
  // Subtract is A + ~B + 1; bit 8 is the carry (1 = no borrow on SUB).
  assign alu_sum = {1'b0, a} + {1'b0, (cw.adder_sub ? ~b : b)} + {8'h00, cw.adder_sub};
  assign alu     = alu_sum[7:0];
`else
  assign alu = a + (cw.adder_sub ? ~b : b) + {7'h00, cw.adder_sub};
`endif

  // Active drivers, in priority order PC > RAM > IR > A > ALU.
  assign drv       = {cw.pc_en, ~cw.ram_en_n, ~cw.ir_en_n, cw.rega_en, cw.regb_en};
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_drv = |(drv & (drv - 5'd1));

  // Bus mux: highest-priority driver wins, idle bus reads as zero.
  always_comb begin
    bus = 8'h00;
    if (cw.pc_en)          bus = {4'h0, pc};
    else if (!cw.ram_en_n) bus = ram[mar];
    else if (!cw.ir_en_n)  bus = {4'h0, ir[3:0]};
    else if (cw.rega_en)   bus = a;
    else if (cw.regb_en)   bus = alu;
  end

  // Bus-loaded registers, PC sequencing and the sticky conflict flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= 4'h0;
      mar          <= 4'h0;
      mdr          <= 8'h00;
      ir           <= 8'h00;
      a            <= 8'h00;
      b            <= 8'h00;
      outr         <= 8'h00;
      bus_conflict <= 1'b0;
    end else begin
      if (!cw.mar_addr_load_n) mar  <= bus[3:0];
      if (!cw.mar_mem_load_n)  mdr  <= bus;
      if (!cw.ir_load_n)       ir   <= bus;
      if (!cw.rega_load_n)     a    <= bus;
      if (!cw.regb_load_n)     b    <= bus;
      if (!cw.out_load_n)      outr <= bus;
      if (cw.pc_load)          pc   <= bus[3:0];
      else if (cw.pc_inc)      pc   <= pc + 4'd1;
      if (multi_drv)           bus_conflict <= 1'b1;
    end
  end

  // RAM writes: no reset on contents; the program port keeps working in
  // reset and, being the later assignment, wins an address collision.
  always_ff @(posedge clk) begin
    if (rst_n && !cw.ram_load_n) ram[mar] <= mdr;
    if (prog_we)                 ram[prog_addr] <= prog_data;
  end

`ifdef SAP1_FLAGS_EN
  // Flags follow the ALU only when its result is being stored into A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (cw.regb_en && !cw.rega_load_n) begin
      zero_flag  <= (alu_sum[7:0] == 8'h00);
      carry_flag <= alu_sum[8];
    end
  end
`else
  assign zero_flag  = 1'b0;
  assign carry_flag = 1'b0;
`endif

  assign opcode  = ir[7:4];
  assign out_val = outr;
  assign bus_dbg = bus;

endmodule
